// File: rtl/mem_access_stage_if.sv
// Bundles the EX/MEM inputs, data-memory handshake and MEM/WB outputs of the MEM stage.
// No latency of its own; it only carries wires.
// Backpressure travels on stall (stage -> hazard unit) and dmem_ack (memory -> stage).
interface mem_access_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    // EX/MEM register outputs
    logic              flush;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] rb_in;
    logic [ADDR_W-1:0] addr_in;
    logic [1:0]        rd_in;
    logic              mem_read_in;
    logic              mem_write_in;
    logic              reg_write_in;
    logic              flag_write_in;

    // data-memory handshake
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    // hazard unit
    logic              stall;

    // MEM/WB register
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        wb_rd;
    logic              wb_reg_write;
    logic              wb_flag_write;

    // The MEM stage itself
    modport master (
        input  flush, alu_result_in, rb_in, addr_in, rd_in,
               mem_read_in, mem_write_in, reg_write_in, flag_write_in,
               dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, stall,
               wb_valid, wb_data, wb_rd, wb_reg_write, wb_flag_write
    );

    // Surrounding pipeline and memory
    modport slave (
        output flush, alu_result_in, rb_in, addr_in, rd_in,
               mem_read_in, mem_write_in, reg_write_in, flag_write_in,
               dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, stall,
               wb_valid, wb_data, wb_rd, wb_reg_write, wb_flag_write
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results to MEM/WB, runs loads/stores over a req/ack memory port.
// Latency: 1 cycle for non-memory ops; 2 cycles minimum for loads/stores plus one per ack wait cycle.
// Backpressure: stall is high from issue until the cycle dmem_ack arrives, holding EX/MEM and earlier stages.
module mem_access_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_access_stage_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              req_q,   req_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              wbv_q,   wbv_d;
    logic [DATA_W-1:0] wbdat_q, wbdat_d;
    logic [1:0]        wbrd_q,  wbrd_d;
    logic              wbrw_q,  wbrw_d;
    logic              wbfw_q,  wbfw_d;

    logic              stall_c;
    logic              is_mem;

    assign is_mem = bus.mem_read_in | bus.mem_write_in;

    // Next-state, request fields, MEM/WB load value and stall; every target gets a default first.
    always_comb begin
        state_nxt = state;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wbv_d     = 1'b0;
        wbdat_d   = '0;
        wbrd_d    = '0;
        wbrw_d    = 1'b0;
        wbfw_d    = 1'b0;
        stall_c   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.flush) begin
                    // cancelled instruction: MEM/WB takes the bubble defaults
                end else if (is_mem) begin
                    // read+write together is a write, so we follows mem_write_in alone
                    stall_c   = 1'b1;
                    req_d     = 1'b1;
                    we_d      = bus.mem_write_in;
                    addr_d    = bus.addr_in;
                    wdata_d   = bus.rb_in;
                    state_nxt = BUSY;
                end else begin
                    wbv_d   = bus.reg_write_in | bus.flag_write_in;
                    wbdat_d = bus.alu_result_in;
                    wbrd_d  = bus.rd_in;
                    wbrw_d  = bus.reg_write_in;
                    wbfw_d  = bus.flag_write_in;
                end
            end
            BUSY: begin
                // flush is ignored here; EX/MEM inputs are held stable by our own stall
                if (bus.dmem_ack) begin
                    req_d     = 1'b0;
                    state_nxt = IDLE;
                    wbv_d     = 1'b1;
                    wbdat_d   = we_q ? bus.alu_result_in : bus.dmem_rdata;
                    wbrd_d    = bus.rd_in;
                    wbrw_d    = bus.reg_write_in;
                    wbfw_d    = bus.flag_write_in;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset wins over a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory request and MEM/WB pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wbv_q   <= 1'b0;
            wbdat_q <= '0;
            wbrd_q  <= '0;
            wbrw_q  <= 1'b0;
            wbfw_q  <= 1'b0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbv_q   <= wbv_d;
            wbdat_q <= wbdat_d;
            wbrd_q  <= wbrd_d;
            wbrw_q  <= wbrw_d;
            wbfw_q  <= wbfw_d;
        end
    end

    assign bus.stall         = stall_c;
    assign bus.dmem_req      = req_q;
    assign bus.dmem_we       = we_q;
    assign bus.dmem_addr     = addr_q;
    assign bus.dmem_wdata    = wdata_q;
    assign bus.wb_valid      = wbv_q;
    assign bus.wb_data       = wbdat_q;
    assign bus.wb_rd         = wbrd_q;
    assign bus.wb_reg_write  = wbrw_q;
    assign bus.wb_flag_write = wbfw_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a transaction-level model.
// Each transaction is driven, the memory acks after a chosen wait, and results are predicted from the rules.
// The bench plays the memory, so backpressure is exercised through the ack delay.
module tb_mem_access_stage;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_access_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_access_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        bus.flush = 0; bus.alu_result_in = 0; bus.rb_in = 0; bus.addr_in = 0; bus.rd_in = 0;
        bus.mem_read_in = 0; bus.mem_write_in = 0; bus.reg_write_in = 0; bus.flag_write_in = 0;
        bus.dmem_ack = 0; bus.dmem_rdata = 0;
    endtask

    // One instruction through the stage. delay = BUSY cycles without ack before the ack cycle.
    task automatic run_txn(input bit rd_op, input bit wr_op, input bit fl,
                           input logic [7:0] alu, input logic [7:0] rb, input logic [7:0] addr,
                           input logic [1:0] rd, input bit rw, input bit fw,
                           input int delay, input logic [7:0] rdata, input bit flush_busy,
                           input bit idle_ack);
        bit mem;
        int stall_cycles;
        int busy_cycles;
        mem = (rd_op | wr_op) & ~fl;
        bus.flush = fl; bus.alu_result_in = alu; bus.rb_in = rb; bus.addr_in = addr; bus.rd_in = rd;
        bus.mem_read_in = rd_op; bus.mem_write_in = wr_op; bus.reg_write_in = rw; bus.flag_write_in = fw;
        bus.dmem_ack = idle_ack; bus.dmem_rdata = ~rdata;
        #1;
        chk("stall_issue", bus.stall, mem);
        if (!mem) begin
            tick();
            chk("req_none", bus.dmem_req, 0);
            chk("wb_valid_pass", bus.wb_valid, fl ? 0 : (rw | fw));
            chk("wb_data_pass", bus.wb_data, fl ? 0 : alu);
            chk("wb_rd_pass", bus.wb_rd, fl ? 0 : rd);
            chk("wb_rw_pass", bus.wb_reg_write, fl ? 0 : rw);
            chk("wb_fw_pass", bus.wb_flag_write, fl ? 0 : fw);
            return;
        end
        stall_cycles = 1;
        busy_cycles = 0;
        bus.dmem_ack = 0;
        tick();
        for (int w = 0; w <= delay; w++) begin
            busy_cycles++;
            chk("req_busy", bus.dmem_req, 1);
            chk("we_busy", bus.dmem_we, wr_op);
            chk("addr_busy", bus.dmem_addr, addr);
            chk("wdata_busy", bus.dmem_wdata, rb);
            chk("wb_bubble", bus.wb_valid, 0);
            bus.flush = flush_busy;
            bus.dmem_ack = (w == delay);
            bus.dmem_rdata = rdata;
            #1;
            if (bus.stall) stall_cycles++;
            tick();
            bus.dmem_ack = 0;
        end
        chk("stall_count", stall_cycles, delay + 1);
        chk("req_cycles", busy_cycles, delay + 1);
        chk("req_drop", bus.dmem_req, 0);
        chk("wb_valid_mem", bus.wb_valid, 1);
        chk("wb_data_mem", bus.wb_data, wr_op ? alu : rdata);
        chk("wb_rd_mem", bus.wb_rd, rd);
        chk("wb_rw_mem", bus.wb_reg_write, rw);
        chk("wb_fw_mem", bus.wb_flag_write, fw);
        bus.flush = 0;
    endtask

    initial begin
        drive_nop();
        bus.mem_read_in = 1;
        rst = 1;
        tick();
        tick();
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_we", bus.dmem_we, 0);
        chk("rst_addr", bus.dmem_addr, 0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_wb_rd", bus.wb_rd, 0);
        chk("rst_wb_rw", bus.wb_reg_write, 0);
        chk("rst_wb_fw", bus.wb_flag_write, 0);
        bus.mem_read_in = 0;
        rst = 0;
        #1;
        chk("rst_stall", bus.stall, 0);

        // ALU pass-through
        run_txn(0, 0, 0, 8'h3C, 8'h00, 8'h00, 2'd2, 1, 0, 0, 8'h00, 0, 0);
        // load, three wait cycles
        run_txn(1, 0, 0, 8'h11, 8'h00, 8'h10, 2'd1, 1, 0, 3, 8'hA5, 0, 0);
        // store, ack on first BUSY cycle
        run_txn(0, 1, 0, 8'h22, 8'h77, 8'h20, 2'd0, 0, 0, 0, 8'h00, 0, 0);
        // flush in IDLE with a store pending
        run_txn(0, 1, 1, 8'h33, 8'h44, 8'h30, 2'd3, 1, 1, 0, 8'h00, 0, 0);
        // flush during BUSY is ignored
        run_txn(1, 0, 0, 8'h55, 8'h00, 8'h40, 2'd2, 1, 1, 2, 8'h5A, 1, 0);
        // read and write together behave as a write
        run_txn(1, 1, 0, 8'h66, 8'h99, 8'h50, 2'd1, 1, 0, 1, 8'hEE, 0, 0);
        // ack in IDLE is ignored
        run_txn(0, 0, 0, 8'h81, 8'h00, 8'h00, 2'd3, 0, 1, 0, 8'h00, 0, 1);

        // reset while BUSY, with ack in the same cycle
        drive_nop();
        bus.mem_read_in = 1; bus.addr_in = 8'h70; bus.reg_write_in = 1;
        tick();
        chk("rstb_req_up", bus.dmem_req, 1);
        rst = 1; bus.dmem_ack = 1; bus.dmem_rdata = 8'hC3;
        tick();
        chk("rstb_req", bus.dmem_req, 0);
        chk("rstb_wb_valid", bus.wb_valid, 0);
        rst = 0;
        drive_nop();
        #1;
        chk("rstb_idle_stall", bus.stall, 0);
        tick();
        chk("rstb_no_wb", bus.wb_valid, 0);

        // randomized mix
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            run_txn(kind == 1 || kind == 3, kind == 2 || kind == 3, ($urandom_range(0, 7) == 0),
                    8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), $urandom_range(0, 4), 8'($urandom),
                    1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
